// File: rtl/counter_4bit_q2.sv
// Loadable up-counter: async active-high clear, active-low synchronous load,
// otherwise increments modulo 2^WIDTH on every rising clk edge.
module counter_4bit_q2 #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // load is active-low; load_data is only consulted when load is 0,
    // so an X on load_data while counting cannot reach the register.
    always_comb begin
        count_d = count_q + WIDTH'(1);
        if (!load) begin
            count_d = load_data;
        end
    end

    // reset_n is active-high despite its name; the port name is kept for
    // interface compatibility.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_counter_4bit_q2.sv
// Table-driven directed test for counter_4bit_q2 with hand-computed expectations.
module tb_counter_4bit_q2;

    logic       clk;
    logic       reset_n;
    logic       load;
    logic [3:0] load_data;
    logic [3:0] count;

    int checks;
    int failures;

    typedef struct {
        logic       rst;
        logic       ld;
        logic [3:0] data;
        logic       mid_rst;  // assert reset halfway through the cycle before the edge
        logic [3:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[$];

    counter_4bit_q2 #(.WIDTH(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (load),
        .load_data (load_data),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input logic [3:0] act, input logic [3:0] exp, input string name);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: count=%b expected=%b", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic ld, input logic [3:0] data,
                       input logic mid_rst, input logic [3:0] exp, input string name);
        vec_t v;
        v.rst = rst; v.ld = ld; v.data = data; v.mid_rst = mid_rst; v.exp = exp; v.name = name;
        vecs.push_back(v);
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        add(1, 1, 4'd0,  0, 4'd0,  "reset_hold_0");
        add(1, 1, 4'd0,  0, 4'd0,  "reset_hold_1");
        add(1, 1, 4'd0,  0, 4'd0,  "reset_hold_2");
        add(0, 1, 4'd0,  0, 4'd1,  "release_1");
        add(0, 1, 4'd0,  0, 4'd2,  "release_2");
        add(0, 1, 4'd0,  0, 4'd3,  "release_3");
        add(0, 0, 4'd3,  0, 4'd3,  "load_3");
        add(0, 1, 4'd0,  0, 4'd4,  "count_4");
        add(0, 1, 4'd0,  0, 4'd5,  "count_5");
        add(0, 1, 4'd0,  0, 4'd6,  "count_6");
        add(0, 1, 4'd0,  0, 4'd7,  "count_7");
        add(0, 1, 4'd0,  1, 4'd0,  "async_held_edge");
        add(1, 0, 4'd9,  0, 4'd0,  "prio_reset_over_load");
        add(0, 0, 4'd9,  0, 4'd9,  "release_into_load_9");
        add(0, 1, 4'd0,  0, 4'd10, "count_10");
        add(0, 0, 4'd5,  0, 4'd5,  "reload_5_a");
        add(0, 0, 4'd5,  0, 4'd5,  "reload_5_b");
        add(0, 1, 4'd0,  0, 4'd6,  "count_6b");
        add(0, 1, 4'd0,  0, 4'd7,  "count_7b");
        add(0, 0, 4'd14, 0, 4'd14, "load_14");
        add(0, 1, 4'd0,  0, 4'd15, "count_15");
        add(0, 1, 4'd0,  0, 4'd0,  "wrap_0");
        add(0, 1, 4'd0,  0, 4'd1,  "wrap_1");
        add(0, 1, 4'bxxxx, 0, 4'd2, "x_data_ignored");

        // Reset applied at time 0 must clear count with no clock edge.
        reset_n   = 1'b1;
        load      = 1'b1;
        load_data = 4'd0;
        #1;
        check(count, 4'd0, "reset_immediate");

        foreach (vecs[i]) begin
            @(negedge clk);
            reset_n   = vecs[i].rst;
            load      = vecs[i].ld;
            load_data = vecs[i].data;
            if (vecs[i].mid_rst) begin
                #2;
                reset_n = 1'b1;
                #1;
                check(count, 4'd0, "async_clear_before_edge");
            end
            @(posedge clk);
            #1;
            check(count, vecs[i].exp, vecs[i].name);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/counter_4bit_q2.md
Name: counter_4bit_q2

Overview:
- 4-bit synchronous up-counter with a parallel load input and an asynchronous reset.
- Used as a general-purpose loadable counter and sequence generator in the control datapath.
- The single output is the registered count value.

Parameters:
- WIDTH, 4, counter and load_data width in bits. All requirements below are written for WIDTH=4 and scale with WIDTH.

Ports:
- clk  input  1  system clock; all state updates occur on its rising edge.
- reset_n  input  1  asynchronous, active-high reset. The port name is kept for interface compatibility; asserted = 1.
- load  input  1  load control, active-low. 0 = load load_data; 1 = count up.
- load_data  input  WIDTH  parallel value captured when load=0.
- count  output  WIDTH  current counter value, registered.

Behaviour:
- One clock domain (clk) and one reset (reset_n: asynchronous, active-high). This is already decided.
- Reset:
  - While reset_n=1, count is forced to 0 immediately, without waiting for a clock edge.
  - count stays 0 for as long as reset_n remains high, and clk, load and load_data are ignored.
- Reset release:
  - reset_n falling to 0 takes effect at the next rising clk edge.
  - The first edge after release evaluates load normally. There is no extra idle cycle.
- Priority per rising edge, highest first:
  1. reset_n=1 -> count=0.
  2. load=0 -> count=load_data.
  3. load=1 -> count=count+1.
- Latency:
  - A load or increment is visible on count one clk edge after the controlling inputs are sampled.
  - There is no combinational path from inputs to count.
- Arithmetic: unsigned, modulo 2^WIDTH. 15 + 1 wraps to 0 with no carry or terminal-count output.
- Load:
  - Fully synchronous; load_data is sampled only on the rising edge with load=0.
  - Holding load=0 for N edges reloads the same value N times; it does not count.
- Load of 15 followed by load=1: count goes 15 -> 0 -> 1 on the following edges.
- Reset mid-operation:
  - Asserting reset_n asynchronously mid-cycle clears count at once.
  - Counting restarts from 0, or from load_data if load=0 at the first edge after release.
- X handling: load_data may be X while load=1 with no effect on count.
- Hold: there is no hold or enable state; with reset deasserted, count changes on every edge.

Test Plan:
- Reset: drive reset_n=1 at time 0 with load=1 and any clk activity -> count=0 immediately, and it stays 0 across 3 edges. Deassert reset_n -> count=1, 2, 3 on the following edges.
- Async reset: with count=7, assert reset_n midway between clock edges -> count=0 before the next rising edge.
- Load then count: load=0, load_data=4'b0011 for one edge -> count=3. Then load=1 -> count=4, 5, 6, 7, 8 on successive edges.
- Reload: while counting, load=0, load_data=4'b0101 for two edges -> count=5, 5. Then load=1 -> count=6, 7, ...
- Wrap-around: load 4'b1110, then load=1 -> count=14, 15, 0, 1 over 4 edges.
- Priority: reset_n=1 and load=0 with load_data=9 on the same edge -> count=0. Release reset_n with load=0 -> count=9 on the next edge.
